// File: rtl/qam_sample_source.sv
// qam_sample_source
//   Burst generator of complex test samples for AGC loop tests. A 16-bit
//   Fibonacci LFSR feeds a QPSK or Gray-coded 16-QAM mapper. Each mapped level
//   is scaled by a programmable amplitude and saturated to 8-bit signed. One
//   symbol is emitted every RATE_DIV clocks.
//
// Parameters
//   RATE_DIV   clocks per symbol (>=1, 1 = a symbol on every clock)
//   LFSR_SEED  LFSR load value at every start (0 is replaced by 16'hACE1)
//
// Ports
//   clk          in   rising-edge system clock
//   rst          in   asynchronous active-low reset
//   start_i      in   pulse, begins a burst (honoured only in IDLE)
//   stop_i       in   pulse, aborts a burst (honoured only in RUN)
//   mod_i        in   0 = QPSK, 1 = 16-QAM (latched at start)
//   amp_i[6:0]   in   unsigned amplitude per unit level (latched at start)
//   burst_len_i  in   symbols per burst, 0 = continuous (latched at start)
//   real_o[7:0]  out  signed in-phase sample (held between strobes)
//   imag_o[7:0]  out  signed quadrature sample (held between strobes)
//   valid_o      out  one-cycle strobe marking a new sample
//   busy_o       out  high while a burst is running
//   done_o       out  one-cycle pulse when a burst ends (count or stop)
module qam_sample_source #(
  parameter int          RATE_DIV  = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        mod_i,
  input  logic [6:0]  amp_i,
  input  logic [15:0] burst_len_i,
  output logic [7:0]  real_o,
  output logic [7:0]  imag_o,
  output logic        valid_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam int DIV_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RATE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(1'b0);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1'b1);

  // x^16+x^14+x^13+x^11+1, feedback bit enters at the LSB
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // QPSK: bit set means -1
  function automatic logic signed [2:0] qpsk_level(input logic b);
    return b ? 3'sb111 : 3'sb001;
  endfunction

  // Gray-coded 4-level axis: 00->-3, 01->-1, 11->+1, 10->+3
  function automatic logic signed [2:0] qam_level(input logic [1:0] b);
    logic signed [2:0] lvl;
    case (b)
      2'b00:   lvl = 3'sb101;
      2'b01:   lvl = 3'sb111;
      2'b11:   lvl = 3'sb001;
      2'b10:   lvl = 3'sb011;
      default: lvl = 3'sb001;
    endcase
    return lvl;
  endfunction

  // level*amp in 10-bit signed (|product| <= 381), then clamp to 8-bit signed
  function automatic logic [7:0] scale_sat(input logic signed [2:0] lvl,
                                           input logic [6:0] amp);
    logic signed [9:0] lvl_x;
    logic signed [9:0] amp_x;
    logic signed [9:0] prod;
    lvl_x = {{7{lvl[2]}}, lvl};
    amp_x = {3'b000, amp};
    prod  = lvl_x * amp_x;
    if (prod > 10'sd127) begin
      return 8'h7F;
    end else if (prod < -10'sd128) begin
      return 8'h80;
    end else begin
      return prod[7:0];
    end
  endfunction

  state_t            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              mod_q, mod_d;
  logic [6:0]        amp_q, amp_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        real_q, real_d;
  logic [7:0]        imag_q, imag_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              sym_due_s;
  logic              last_sym_s;
  logic              emit_s;
  logic signed [2:0] real_lvl_s;
  logic signed [2:0] imag_lvl_s;

  // Symbol timing and mapping of the current LFSR nibble
  always_comb begin
    sym_due_s  = (div_q == DIV_ZERO);
    last_sym_s = (len_q != 16'd0) && ((cnt_q + 16'd1) == len_q);
    // A final symbol wins over a coincident stop; otherwise stop suppresses it
    emit_s     = (state_q == ST_RUN) && sym_due_s && (!stop_i || last_sym_s);
    if (mod_q) begin
      real_lvl_s = qam_level(lfsr_q[1:0]);
      imag_lvl_s = qam_level(lfsr_q[3:2]);
    end else begin
      real_lvl_s = qpsk_level(lfsr_q[0]);
      imag_lvl_s = qpsk_level(lfsr_q[1]);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (emit_s && last_sym_s) begin
          state_d = ST_DONE;
        end else if (stop_i) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    lfsr_d  = lfsr_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    mod_d   = mod_q;
    amp_d   = amp_q;
    len_d   = len_q;
    real_d  = real_q;
    imag_d  = imag_q;
    valid_d = 1'b0;
    busy_d  = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
    if ((state_q == ST_IDLE) && start_i) begin
      mod_d  = mod_i;
      amp_d  = amp_i;
      len_d  = burst_len_i;
      lfsr_d = SEED_EFF;
      div_d  = DIV_ZERO;
      cnt_d  = 16'd0;
    end else if (state_q == ST_RUN) begin
      if (div_q == DIV_LAST) begin
        div_d = DIV_ZERO;
      end else begin
        div_d = div_q + DIV_ONE;
      end
      if (emit_s) begin
        real_d  = scale_sat(real_lvl_s, amp_q);
        imag_d  = scale_sat(imag_lvl_s, amp_q);
        valid_d = 1'b1;
        lfsr_d  = lfsr_step(lfsr_q);
        cnt_d   = cnt_q + 16'd1;
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q  <= SEED_EFF;
      div_q   <= DIV_ZERO;
      cnt_q   <= 16'd0;
      mod_q   <= 1'b0;
      amp_q   <= 7'd0;
      len_q   <= 16'd0;
      real_q  <= 8'd0;
      imag_q  <= 8'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      mod_q   <= mod_d;
      amp_q   <= amp_d;
      len_q   <= len_d;
      real_q  <= real_d;
      imag_q  <= imag_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign real_o  = real_q;
  assign imag_o  = imag_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_qam_sample_source.sv
// Directed bench for qam_sample_source (RATE_DIV=4, seed 16'hACE1).
module tb_qam_sample_source;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        stop_i;
  logic        mod_i;
  logic [6:0]  amp_i;
  logic [15:0] burst_len_i;
  logic [7:0]  real_o;
  logic [7:0]  imag_o;
  logic        valid_o;
  logic        busy_o;
  logic        done_o;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_lfsr;
  logic        m_mod;
  int          m_amp;

  qam_sample_source #(.RATE_DIV(RD), .LFSR_SEED(16'hACE1)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .mod_i       (mod_i),
    .amp_i       (amp_i),
    .burst_len_i (burst_len_i),
    .real_o      (real_o),
    .imag_o      (imag_o),
    .valid_o     (valid_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] to8(input int v);
    return {24'h000000, v[7:0]};
  endfunction

  function automatic logic [15:0] m_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic int m_gray(input logic [1:0] b);
    case (b)
      2'b00:   return -3;
      2'b01:   return -1;
      2'b11:   return 1;
      default: return 3;
    endcase
  endfunction

  // Expected saturated sample for one axis of the symbol taken from lfsr[3:0]
  function automatic int m_sample(input logic [15:0] l, input logic md, input int amp,
                                  input bit is_imag);
    int lvl;
    int v;
    if (md) lvl = is_imag ? m_gray(l[3:2]) : m_gray(l[1:0]);
    else    lvl = (is_imag ? l[1] : l[0]) ? -1 : 1;
    v = lvl * amp;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  task automatic do_start(input logic md, input logic [6:0] amp, input logic [15:0] len);
    @(negedge clk);
    mod_i       = md;
    amp_i       = amp;
    burst_len_i = len;
    start_i     = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    m_lfsr  = 16'hACE1;
    m_mod   = md;
    m_amp   = int'(amp);
  endtask

  // Watches n cycles after a start, checking every strobe against the model.
  // stop_after>0 raises stop_i on the edge where symbol stop_after+1 is due.
  // inject_at>0 pulses start_i and changes config mid-burst (must be ignored).
  task automatic monitor(input int n, input int stop_after, input int inject_at,
                         output int nvalid, output int ndone,
                         output int last_idx, output int done_idx);
    int since;
    since    = 0;
    nvalid   = 0;
    ndone    = 0;
    last_idx = -1;
    done_idx = -2;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      stop_i  = 1'b0;
      start_i = 1'b0;
      if (valid_o) begin
        nvalid++;
        if (nvalid == 1) check_eq("first_valid_idx", i, 1);
        else             check_eq("valid_spacing", i - last_idx, RD);
        check_eq("sym_real", {24'h0, real_o}, to8(m_sample(m_lfsr, m_mod, m_amp, 1'b0)));
        check_eq("sym_imag", {24'h0, imag_o}, to8(m_sample(m_lfsr, m_mod, m_amp, 1'b1)));
        m_lfsr   = m_next(m_lfsr);
        last_idx = i;
        since    = 0;
      end else begin
        since++;
      end
      if (done_o) begin
        ndone++;
        done_idx = i;
      end
      if (stop_after > 0 && nvalid == stop_after && since == RD - 1 && ndone == 0)
        stop_i = 1'b1;
      if (i == inject_at) begin
        start_i     = 1'b1;
        amp_i       = 7'd5;
        mod_i       = ~mod_i;
        burst_len_i = 16'd2;
      end
    end
  endtask

  int nv, nd, lv, di;

  initial begin
    rst = 1'b0; start_i = 1'b0; stop_i = 1'b0; mod_i = 1'b0;
    amp_i = 7'd0; burst_len_i = 16'd0;
    m_lfsr = 16'hACE1; m_mod = 1'b0; m_amp = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_real",  {24'h0, real_o}, 32'h0);
    check_eq("rst_imag",  {24'h0, imag_o}, 32'h0);
    check_eq("rst_valid", {31'h0, valid_o}, 32'h0);
    check_eq("rst_busy",  {31'h0, busy_o}, 32'h0);
    check_eq("rst_done",  {31'h0, done_o}, 32'h0);
    rst = 1'b1;

    // 1: QPSK amp 64, len 1: symbol 0001 -> real -64, imag +64
    do_start(1'b0, 7'd64, 16'd1);
    check_eq("t1_busy_run", {31'h0, busy_o}, 32'h1);
    check_eq("t1_no_valid_at_start", {31'h0, valid_o}, 32'h0);
    @(negedge clk);
    check_eq("t1_valid", {31'h0, valid_o}, 32'h1);
    check_eq("t1_real", {24'h0, real_o}, 32'hC0);
    check_eq("t1_imag", {24'h0, imag_o}, 32'h40);
    check_eq("t1_done", {31'h0, done_o}, 32'h1);
    check_eq("t1_busy_end", {31'h0, busy_o}, 32'h0);
    @(negedge clk);
    check_eq("t1_valid_off", {31'h0, valid_o}, 32'h0);
    check_eq("t1_done_off", {31'h0, done_o}, 32'h0);
    check_eq("t1_real_hold", {24'h0, real_o}, 32'hC0);

    // 2: 16-QAM amp 50: real -50, imag -150 saturates to -128
    do_start(1'b1, 7'd50, 16'd1);
    @(negedge clk);
    check_eq("t2_valid", {31'h0, valid_o}, 32'h1);
    check_eq("t2_real", {24'h0, real_o}, 32'hCE);
    check_eq("t2_imag", {24'h0, imag_o}, 32'h80);

    // 3+5: 16-QAM len 10, restart/config change mid-burst ignored
    do_start(1'b1, 7'd20, 16'd10);
    monitor(60, 0, 10, nv, nd, lv, di);
    check_eq("t3_nvalid", nv, 10);
    check_eq("t3_ndone", nd, 1);
    check_eq("t3_done_with_last", di, lv);
    check_eq("t3_busy_after", {31'h0, busy_o}, 32'h0);

    // 4: continuous QPSK, stop on a due edge after 7 symbols
    do_start(1'b0, 7'd100, 16'd0);
    monitor(60, 7, 0, nv, nd, lv, di);
    check_eq("t4_nvalid", nv, 7);
    check_eq("t4_ndone", nd, 1);
    check_eq("t4_done_idx", di, lv + RD);
    check_eq("t4_busy_after", {31'h0, busy_o}, 32'h0);

    // 6: async reset mid-burst, then symbol 1 reproduced
    do_start(1'b0, 7'd64, 16'd0);
    repeat (5) @(negedge clk);
    check_eq("t6_busy_pre", {31'h0, busy_o}, 32'h1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("t6_real_rst", {24'h0, real_o}, 32'h0);
    check_eq("t6_imag_rst", {24'h0, imag_o}, 32'h0);
    check_eq("t6_busy_rst", {31'h0, busy_o}, 32'h0);
    check_eq("t6_valid_rst", {31'h0, valid_o}, 32'h0);
    check_eq("t6_done_rst", {31'h0, done_o}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    do_start(1'b0, 7'd64, 16'd1);
    @(negedge clk);
    check_eq("t6_valid", {31'h0, valid_o}, 32'h1);
    check_eq("t6_real", {24'h0, real_o}, 32'hC0);
    check_eq("t6_imag", {24'h0, imag_o}, 32'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
